rf8088_fta_scratch_mem: RTL
===========================

Name: rf8088_fta_scratch_mem

Overview:
- FTA-bus responder (slave) serving the rf8088 core's byte-lane requests from a 128-bit-wide on-chip scratch RAM.
- Sits on the far side of ftam_req/ftam_resp and answers the single-cycle cyc/stb pulses the core issues.
- Accepts one request at a time with a programmable read latency.
- Returns a whole 128-bit line on ack; the master does its own byte-lane extraction.
- Tells a master to retry (rty) when a request arrives while the single slot is busy.

Parameters:
- BASE, 20'hF0000, 20-bit physical base address of the window.
- MASK, 20'hF0000, address bits compared against BASE. Must cover all bits above the RAM depth.
- DEPTH, 4096, number of 128-bit lines. Power of two; window = DEPTH*16 bytes.
- LAT, 2, cycles from request accept to ack. Legal range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- ftas_req  in  fta_cmd_request128_t  request. Fields used: cyc, stb, we, sel[15:0], padr[19:0], data1[127:0], tid. Fields ignored: vadr, blen, bte, cti, padr[31:20].
- ftas_resp  out  fta_cmd_response128_t  response. Fields driven: ack, rty, err (tied 0), dat[127:0], tid, adr. All other fields are 0.
- ovf_o  out  1  sticky flag: a retry was lost. Cleared only by reset.

Behaviour:
- Reset (rst_i low, async): ack=0, rty=0, dat=0, tid=0, adr=0, ovf_o=0, state=IDLE, retry slot empty. RAM contents are not reset.
- Address decode: hit = cyc & stb & ((padr[19:0] & MASK) == (BASE & MASK)).
  - padr[31:20] carries random bits from the master and must never influence decode.
  - Line index = padr[log2(DEPTH)+3:4].
- Request is a one-cycle pulse. The master does not hold it; the responder never back-pressures via stall.
- A miss (no hit) produces no response of any kind.
- State machine: IDLE, BUSY.
  - IDLE + hit: accept the request. Latch tid, padr[19:0], we, line index. Load countdown = LAT-1. Go to BUSY.
  - Write accept: in the accept cycle, bytes where sel[i]=1 take data1[8i+7:8i]; other bytes are unchanged. sel=0 writes nothing but is still acked.
  - BUSY: countdown decrements each cycle. When it is 0 and the state is BUSY, drive the registered response for one cycle:
    - ack=1, tid = latched tid, adr = {12'd0, latched padr}.
    - dat = RAM line for a read, or 128'd0 for a write.
  - Read data reflects every write accepted before the read was accepted.
  - Ack cycle frees the slot. A hit in the ack cycle is accepted (stay BUSY, reload countdown) with no gap.
  - BUSY + hit, not the ack cycle: reject. Write is not performed. Retry slot records tid and adr.
- Retry output: rty=1, with that tid and adr, appears one cycle after the rejected request.
  - If that cycle carries an ack, ack wins. rty stays pending in the slot and is emitted on the next cycle with no ack.
  - The slot holds one entry. A new reject while the slot is full overwrites it (newest wins) and sets ovf_o.
- ack and rty are never high in the same cycle. Each pulse lasts exactly one cycle. dat=0 on rty and idle cycles.
- LAT=1: ack appears the cycle after accept, and back-to-back requests every cycle are all acked, never retried.
- Reset mid-operation: the pending transaction and retry slot are discarded with no ack or rty. A write already committed in the accept cycle stays in RAM.

Test Plan:
- Write then read, LAT=2: write padr=20'hF0013, sel=16'h0008, data1={16{8'hA5}} -> ack at accept+2, dat=0, tid echoed. Read of 20'hF0010 -> ack at accept+2, dat[31:24]=8'hA5, other bytes unchanged.
- Upper-bit garbage: two requests with padr=32'h7A3F0020 and 32'h000F0020 -> both decode to line 2 and return identical data. Request padr[19:0]=20'h10020 -> no ack, no rty.
- Collision: read tid=5 accepted, read tid=6 issued the next cycle (LAT=3) -> rty tid=6 at cycle+2, ack tid=5 at cycle+3. A write rejected the same way leaves RAM unchanged.
- Retry/ack overlap: reject timed so rty coincides with ack -> ack first, rty the following cycle. Then two rejects with no intervening free cycle -> only the newest tid gets rty, ovf_o=1.
- LAT=1 streaming: 8 consecutive single-cycle reads -> 8 acks on consecutive cycles, correct tids and data, zero rty.
- Async reset asserted while BUSY -> outputs zero immediately with no clock edge needed. After release, no stale ack or rty appears and a new request is served normally.

Source files
------------

// File: rtl/rf8088_fta_scratch_mem_if.sv
// FTA request/response bundle between the rf8088 core (master) and a 128-bit responder (slave).
interface rf8088_fta_scratch_mem_if;
    logic         req_cyc;
    logic         req_stb;
    logic         req_we;
    logic [15:0]  req_sel;
    logic [31:0]  req_padr;
    logic [127:0] req_data1;
    logic [12:0]  req_tid;
    logic         resp_ack;
    logic         resp_rty;
    logic         resp_err;
    logic [127:0] resp_dat;
    logic [12:0]  resp_tid;
    logic [31:0]  resp_adr;

    modport master (
        output req_cyc, req_stb, req_we, req_sel, req_padr, req_data1, req_tid,
        input  resp_ack, resp_rty, resp_err, resp_dat, resp_tid, resp_adr
    );

    modport slave (
        input  req_cyc, req_stb, req_we, req_sel, req_padr, req_data1, req_tid,
        output resp_ack, resp_rty, resp_err, resp_dat, resp_tid, resp_adr
    );
endinterface

// File: rtl/rf8088_fta_scratch_mem.sv
// Single-slot FTA responder backed by a 128-bit-wide scratch RAM, with programmable
// read latency and a one-entry retry slot for requests that hit while busy.
module rf8088_fta_scratch_mem #(
    parameter logic [19:0] BASE  = 20'hF0000,
    parameter logic [19:0] MASK  = 20'hF0000,
    parameter int          DEPTH = 4096,
    parameter int          LAT   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    rf8088_fta_scratch_mem_if.slave        ftas,
    output logic                           ovf_o
);
    localparam int         IDXW     = $clog2(DEPTH);
    localparam int         TIDW     = 13;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    logic [0:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            slot_vld_q, slot_vld_d;
    logic            ovf_q, ovf_d;
    logic [TIDW-1:0] tid_q, slot_tid_q;
    logic [19:0]     padr_q, slot_adr_q;
    logic            we_q;
    logic [127:0]    rdata_q;
    logic [127:0]    mem [DEPTH];

    logic            hit, fire, accept, reject, rty_emit;
    logic [IDXW-1:0] idx;
    logic            unused_upper;

    // The master puts random bits in padr[31:20]; they never reach the decode.
    assign unused_upper = ^ftas.req_padr[31:20];
    assign hit      = ftas.req_cyc & ftas.req_stb &
                      ((ftas.req_padr[19:0] & MASK) == (BASE & MASK));
    assign idx      = ftas.req_padr[IDXW+3:4];
    assign fire     = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign accept   = hit && ((state_q == ST_IDLE) || fire);
    assign reject   = hit && !accept;
    // A reject landing on a full slot replaces the pending entry before it can go out.
    assign rty_emit = slot_vld_q && !fire && !reject;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_vld_d = slot_vld_q;
        ovf_d      = ovf_q;
        if (accept) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
        end else if (fire) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (reject) begin
            slot_vld_d = 1'b1;
            if (slot_vld_q) ovf_d = 1'b1;
        end else if (rty_emit) begin
            slot_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            slot_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_vld_q <= slot_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    // Read data is captured at accept so any later write cannot disturb the pending read.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tid_q   <= ftas.req_tid;
            padr_q  <= ftas.req_padr[19:0];
            we_q    <= ftas.req_we;
            rdata_q <= mem[idx];
            if (ftas.req_we) begin
                for (int i = 0; i < 16; i++) begin
                    if (ftas.req_sel[i]) mem[idx][8*i +: 8] <= ftas.req_data1[8*i +: 8];
                end
            end
        end
        if (reject) begin
            slot_tid_q <= ftas.req_tid;
            slot_adr_q <= ftas.req_padr[19:0];
        end
    end

    always_comb begin
        ftas.resp_ack = fire;
        ftas.resp_rty = rty_emit;
        ftas.resp_err = 1'b0;
        ftas.resp_dat = '0;
        ftas.resp_tid = '0;
        ftas.resp_adr = '0;
        if (fire) begin
            ftas.resp_dat = we_q ? 128'd0 : rdata_q;
            ftas.resp_tid = tid_q;
            ftas.resp_adr = {12'd0, padr_q};
        end else if (rty_emit) begin
            ftas.resp_tid = slot_tid_q;
            ftas.resp_adr = {12'd0, slot_adr_q};
        end
    end

    assign ovf_o = ovf_q;
endmodule
